i2c_mon_capture: RTL

- Capture controller between the I2C bus-monitor receiver event outputs and a host read port.
- Sequences capture runs: arm, filter by 7-bit target address, record matching transactions as encoded event words in an internal FIFO, stop after a programmed transaction count.
- Host drains the FIFO with a simple read-enable handshake; status flags report busy, done and overflow.

---
 rtl/i2c_mon_capture_if.sv | 36 +++
 rtl/i2c_mon_capture.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_mon_capture_if.sv
// Bus bundle for i2c_mon_capture: receiver event inputs plus the host read port.
// Macro I2C_MON_CAPTURE_TIMESTAMP_EN widens rd_data from 12 to 28 bits.
interface i2c_mon_capture_if #(
  parameter int LEVEL_W = 5
);
`ifdef I2C_MON_CAPTURE_TIMESTAMP_EN
  localparam int W = 28;
`else
  localparam int W = 12;
`endif

  logic               mon_valid;
  logic [7:0]         mon_byte;
  logic               mon_ack;
  logic               mon_short;
  logic               mon_start;
  logic               mon_stop;
  logic               mon_notrans;
  logic               rd_en;
  logic [W-1:0]       rd_data;
  logic               rd_empty;
  logic [LEVEL_W-1:0] fifo_level;

  // master = receiver + host side, slave = capture controller
  modport master (
    output mon_valid, mon_byte, mon_ack, mon_short, mon_start, mon_stop, mon_notrans,
    output rd_en,
    input  rd_data, rd_empty, fifo_level
  );

  modport slave (
    input  mon_valid, mon_byte, mon_ack, mon_short, mon_start, mon_stop, mon_notrans,
    input  rd_en,
    output rd_data, rd_empty, fifo_level
  );
endinterface

// File: rtl/i2c_mon_capture.sv
// Capture controller: filters I2C monitor events by address and records them in a show-ahead FIFO.
// Define I2C_MON_CAPTURE_TIMESTAMP_EN to prefix each word with a 16-bit free-running timestamp.
module i2c_mon_capture #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEVEL_W    = 5
) (
  input  logic                    clk,
  input  logic                    reset_l,
  i2c_mon_capture_if.slave        bus,
  input  logic                    cfg_arm,
  input  logic                    cfg_abort,
  input  logic [6:0]              cfg_addr,
  input  logic [6:0]              cfg_mask,
  input  logic [7:0]              cfg_count,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);
`ifdef I2C_MON_CAPTURE_TIMESTAMP_EN
  localparam int W = 28;
`else
  localparam int W = 12;
`endif
  localparam int PTR_W = LEVEL_W - 1;
  localparam logic [11:0] START_WORD = 12'h400;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t             state;
  logic               start_pend;
  logic [7:0]         txn_cnt;
  logic               defer_valid;
  logic [W-1:0]       defer_word;

  logic               addr_hit;
  logic [11:0]        byte_base;
  logic [11:0]        bound_base;
  logic               ev_push;
  logic [11:0]        ev_base;
  logic               dv_set;
  logic [11:0]        dv_base;
  logic [W-1:0]       ev_word;
  logic [W-1:0]       dv_word;

  logic               push_req;
  logic [W-1:0]       push_word;
  logic               push_ok;
  logic               pop;
  logic               full;
  logic               empty;
  logic               flush;

  logic [W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;

`ifdef I2C_MON_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) ts <= 16'd0;
    else          ts <= ts + 16'd1;
  end

  // Deferred words carry the stamp of the cycle their event arrived in
  assign ev_word = {ts, ev_base};
  assign dv_word = {ts, dv_base};
`else
  assign ev_word = ev_base;
  assign dv_word = dv_base;
`endif

  // Decode this cycle's receiver event into at most one immediate word and one deferred word
  always_comb begin
    addr_hit   = ((bus.mon_byte[7:1] ^ cfg_addr) & cfg_mask) == 7'd0;
    byte_base  = {2'd0, bus.mon_short, bus.mon_ack, bus.mon_byte};
    bound_base = bus.mon_start ? 12'hC00 : {2'd2, bus.mon_notrans, 1'b0, 8'h00};
    ev_push    = 1'b0;
    ev_base    = byte_base;
    dv_set     = 1'b0;
    dv_base    = bound_base;
    if (!cfg_abort && !cfg_arm && !defer_valid) begin
      case (state)
        ARMED: begin
          if (!bus.mon_start && !bus.mon_stop && bus.mon_valid && start_pend && addr_hit) begin
            ev_push = 1'b1;
            ev_base = START_WORD;
            dv_set  = 1'b1;
            dv_base = byte_base;
          end
        end
        CAPTURE: begin
          if (bus.mon_valid) begin
            ev_push = 1'b1;
            ev_base = byte_base;
            dv_set  = bus.mon_stop;
            dv_base = bound_base;
          end else if (bus.mon_stop) begin
            ev_push = 1'b1;
            ev_base = bound_base;
          end
        end
        default: ;
      endcase
    end
  end

  assign flush     = cfg_arm & ~cfg_abort;
  assign push_req  = (defer_valid & ~cfg_abort & ~cfg_arm) | ev_push;
  assign push_word = defer_valid ? defer_word : ev_word;
  assign full      = (level == LEVEL_W'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign pop       = bus.rd_en & ~empty;
  assign push_ok   = push_req & (~full | pop);

  // Run sequencing; abort outranks arm, and both outrank receiver events
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= IDLE;
      start_pend  <= 1'b0;
      txn_cnt     <= 8'd0;
      done        <= 1'b0;
      defer_valid <= 1'b0;
      defer_word  <= '0;
    end else if (cfg_abort) begin
      state       <= IDLE;
      start_pend  <= 1'b0;
      defer_valid <= 1'b0;
    end else if (cfg_arm) begin
      state       <= ARMED;
      start_pend  <= 1'b0;
      defer_valid <= 1'b0;
      done        <= 1'b0;
      txn_cnt     <= cfg_count;
    end else begin
      defer_valid <= dv_set;
      if (dv_set) defer_word <= dv_word;
      case (state)
        ARMED: begin
          if (bus.mon_start) begin
            start_pend <= 1'b1;
          end else if (bus.mon_stop) begin
            start_pend <= 1'b0;
          end else if (bus.mon_valid && start_pend) begin
            start_pend <= 1'b0;
            if (addr_hit) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.mon_stop && !bus.mon_start) begin
            if (cfg_count == 8'd0) begin
              state <= ARMED;
            end else if (txn_cnt <= 8'd1) begin
              txn_cnt <= 8'd0;
              state   <= IDLE;
              done    <= 1'b1;
            end else begin
              txn_cnt <= txn_cnt - 8'd1;
              state   <= ARMED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // A pop in the same cycle frees room, so a push against a full FIFO still lands
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      level <= level + 1'b1;
      else if (pop && !push_ok) level <= level - 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  assign bus.rd_data    = empty ? '0 : mem[rd_ptr];
  assign bus.rd_empty   = empty;
  assign bus.fifo_level = level;
  assign busy           = (state != IDLE);

endmodule
